// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR tap read sequencer.
package fir_pkg;

    localparam int TAPS_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tap_seq_state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Beat stream from the tap sequencer to the MAC datapath (valid/ready).
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 6
) ();
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ADDR_W-1:0] sample_addr;
    logic [ADDR_W-1:0] coef_addr;

    modport master (
        output out_valid, sample_addr, coef_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, sample_addr, coef_addr, out_last,
        output out_ready
    );
endinterface

// File: rtl/mod_down_counter.sv
// Modulo-MOD down counter: 0 wraps to MOD-1, never to the natural 2**W rollover.
module mod_down_counter #(
    parameter int MOD = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [$clog2(MOD)-1:0] load_val,
    input  logic                   dec,
    output logic [$clog2(MOD)-1:0] value,
    output logic                   wrap
);
    localparam int W = $clog2(MOD);
    localparam logic [W-1:0] TOP = W'(MOD - 1);

    assign wrap = dec && (value == '0);

    // load takes priority so a new pass always starts from a clean address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= (value == '0) ? TOP : value - W'(1);
        end
    end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Walks the FIR delay line newest-to-oldest, one tap per accepted beat.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS = TAPS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [$clog2(TAPS)-1:0] wr_ptr,
    output logic                    busy,
    output logic                    done,
    fir_tap_sequencer_if.master     bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    tap_seq_state_t    state;
    logic              valid_q;
    logic [ADDR_W-1:0] coef_q;
    logic [ADDR_W-1:0] sample_q;
    logic [ADDR_W-1:0] start_addr;
    logic              start_ok;
    logic              accept;
    logic              last_accept;
    logic              unused_wrap;

    assign start_ok    = (state == IDLE) && start && !abort;
    assign accept      = valid_q && bus.out_ready;
    assign last_accept = accept && (coef_q == LAST_IDX);

    // Out-of-range write pointers (only possible when TAPS is not a power of 2)
    assign start_addr = (int'(wr_ptr) >= TAPS) ? LAST_IDX : wr_ptr;

    mod_down_counter #(
        .MOD (TAPS)
    ) u_sample_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (start_addr),
        .dec      (accept && !abort),
        .value    (sample_q),
        .wrap     (unused_wrap)
    );

    // Control FSM; every status output is a register so the MAC sees clean edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            coef_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        coef_q  <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (last_accept) begin
                        state   <= DONE;
                        valid_q <= 1'b0;
                        done    <= 1'b1;
                        coef_q  <= '0;
                    end else if (accept) begin
                        coef_q  <= coef_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.sample_addr = sample_q;
    assign bus.coef_addr   = coef_q;
    assign bus.out_last    = valid_q && (coef_q == LAST_IDX);
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench: one 64-tap and one 5-tap sequencer instance.
module tb_fir_tap_sequencer;
    logic clk;
    logic rst;

    logic       start64, abort64, busy64, done64;
    logic [5:0] wr64;
    logic       start5, abort5, busy5, done5;
    logic [2:0] wr5;

    int total;
    int bad;

    fir_tap_sequencer_if #(.ADDR_W(6)) if64 ();
    fir_tap_sequencer_if #(.ADDR_W(3)) if5 ();

    fir_tap_sequencer #(.TAPS(64)) u64 (
        .clk    (clk),
        .rst    (rst),
        .start  (start64),
        .abort  (abort64),
        .wr_ptr (wr64),
        .busy   (busy64),
        .done   (done64),
        .bus    (if64.master)
    );

    fir_tap_sequencer #(.TAPS(5)) u5 (
        .clk    (clk),
        .rst    (rst),
        .start  (start5),
        .abort  (abort5),
        .wr_ptr (wr5),
        .busy   (busy5),
        .done   (done5),
        .bus    (if5.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap_sub(input int wr, input int k, input int taps);
        return ((wr - k) % taps + taps) % taps;
    endfunction

    // Caller sits on a negedge; returns on the negedge showing beat 0
    task automatic kick64(input int wr);
        wr64    = 6'(wr);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
    endtask

    task automatic kick5(input int wr);
        wr5    = 3'(wr);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        rst = 1'b1;
        start64 = 0; abort64 = 0; wr64 = '0; if64.out_ready = 1'b1;
        start5  = 0; abort5  = 0; wr5  = '0; if5.out_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last, busy64, done64};
        total++;
        if (got !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset64 got=%h want=0000", got);
        end
        total++;
        if ({if5.out_valid, if5.sample_addr, if5.coef_addr, if5.out_last, busy5, done5} !== 10'h0) begin
            bad++;
            $display("[TB] FAIL reset5 got=%h want=000",
                     {if5.out_valid, if5.sample_addr, if5.coef_addr, if5.out_last, busy5, done5});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [13:0] got, exp;
        if64.out_ready = 1'b1;
        kick64(10);
        for (int k = 0; k < 64; k++) begin
            got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last};
            exp = {1'b1, 6'(wrap_sub(10, k, 64)), 6'(k), (k == 63)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL basic beat%0d got=%h want=%h", k, got, exp);
            end
            @(negedge clk);
        end
        total++;
        if ({if64.out_valid, done64, busy64} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL basic_done got=%b want=011", {if64.out_valid, done64, busy64});
        end
        @(negedge clk);
        total++;
        if ({if64.out_valid, done64, busy64} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL basic_idle got=%b want=000", {if64.out_valid, done64, busy64});
        end
    endtask

    task automatic test_wrap5();
        logic [6:0] got, exp;
        int seq [5] = '{1, 0, 4, 3, 2};
        if5.out_ready = 1'b1;
        kick5(1);
        for (int k = 0; k < 5; k++) begin
            got = {if5.out_valid, if5.sample_addr, if5.coef_addr};
            exp = {1'b1, 3'(seq[k]), 3'(k)};
            total++;
            if (got !== exp || if5.out_last !== (k == 4)) begin
                bad++;
                $display("[TB] FAIL wrap5 beat%0d got=%h last=%b want=%h", k, got, if5.out_last, exp);
            end
            @(negedge clk);
        end
        total++;
        if ({if5.out_valid, done5} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL wrap5_done got=%b want=01", {if5.out_valid, done5});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [13:0] got, exp;
        int  k = 0;
        int  cyc = 0;
        bit  seen_done = 0;
        if64.out_ready = 1'b0;
        kick64(40);
        while (cyc < 1000 && !seen_done) begin
            if (done64 === 1'b1) begin
                seen_done = 1;
                total++;
                if (k != 64) begin
                    bad++;
                    $display("[TB] FAIL bp_count got=%0d want=64", k);
                end
            end else begin
                got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last};
                exp = {1'b1, 6'(wrap_sub(40, k, 64)), 6'(k), (k == 63)};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("[TB] FAIL bp beat%0d got=%h want=%h", k, got, exp);
                end
                if64.out_ready = 1'($urandom_range(0, 1));
                if (if64.out_ready) k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen_done) begin
            total++;
            bad++;
            $display("[TB] FAIL bp_timeout got=no_done want=done");
        end
        if64.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        logic [13:0] got, exp;
        if64.out_ready = 1'b1;
        kick64(20);
        for (int k = 0; k < 64; k++) begin
            got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last};
            exp = {1'b1, 6'(wrap_sub(20, k, 64)), 6'(k), (k == 63)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL busy_start beat%0d got=%h want=%h", k, got, exp);
            end
            start64 = (k == 3);
            wr64    = (k == 3) ? 6'd5 : 6'd20;
            @(negedge clk);
            start64 = 1'b0;
        end
        total++;
        if (done64 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_done got=%b want=1", done64);
        end
        wr64    = 6'd5;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({if64.out_valid, busy64, done64} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL busy_noqueue%0d got=%b want=000", i, {if64.out_valid, busy64, done64});
            end
            @(negedge clk);
        end
        kick64(7);
        total++;
        if ({if64.out_valid, if64.sample_addr, if64.coef_addr} !== {1'b1, 6'd7, 6'd0}) begin
            bad++;
            $display("[TB] FAIL busy_restart got=%h want=%h",
                     {if64.out_valid, if64.sample_addr, if64.coef_addr}, {1'b1, 6'd7, 6'd0});
        end
        abort64 = 1'b1;
        @(negedge clk);
        abort64 = 1'b0;
    endtask

    task automatic test_abort();
        logic [13:0] got, exp;
        if64.out_ready = 1'b1;
        kick64(30);
        for (int k = 0; k <= 20; k++) begin
            got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last};
            exp = {1'b1, 6'(wrap_sub(30, k, 64)), 6'(k), 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL abort20 beat%0d got=%h want=%h", k, got, exp);
            end
            abort64 = (k == 20);
            @(negedge clk);
        end
        abort64 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({if64.out_valid, busy64, done64} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL abort20_idle%0d got=%b want=000", i, {if64.out_valid, busy64, done64});
            end
            @(negedge clk);
        end
        kick64(0);
        for (int k = 0; k < 64; k++) begin
            abort64 = (k == 63);
            @(negedge clk);
        end
        abort64 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({if64.out_valid, busy64, done64} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL abort_last%0d got=%b want=000", i, {if64.out_valid, busy64, done64});
            end
            @(negedge clk);
        end
        // abort and start together in IDLE: start is dropped
        start64 = 1'b1;
        abort64 = 1'b1;
        wr64    = 6'd9;
        @(negedge clk);
        start64 = 1'b0;
        abort64 = 1'b0;
        total++;
        if ({if64.out_valid, busy64} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL abort_start got=%b want=00", {if64.out_valid, busy64});
        end
        kick64(0);
        for (int k = 0; k < 3; k++) begin
            got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last};
            exp = {1'b1, 6'(wrap_sub(0, k, 64)), 6'(k), 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL abort_restart beat%0d got=%h want=%h", k, got, exp);
            end
            @(negedge clk);
        end
        abort64 = 1'b1;
        @(negedge clk);
        abort64 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        if64.out_ready = 1'b1;
        kick64(50);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        got = {if64.out_valid, if64.sample_addr, if64.coef_addr, if64.out_last, busy64, done64};
        total++;
        if (got !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid got=%h want=0000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({if64.out_valid, done64} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_mid_after got=%b want=00", {if64.out_valid, done64});
        end
    endtask

    task automatic test_range();
        int wrs [2] = '{7, 5};
        if5.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            kick5(wrs[i]);
            total++;
            if ({if5.out_valid, if5.sample_addr, if5.coef_addr} !== {1'b1, 3'd4, 3'd0}) begin
                bad++;
                $display("[TB] FAIL range wr=%0d got=%h want=%h", wrs[i],
                         {if5.out_valid, if5.sample_addr, if5.coef_addr}, {1'b1, 3'd4, 3'd0});
            end
            @(negedge clk);
            total++;
            if (if5.sample_addr !== 3'd3) begin
                bad++;
                $display("[TB] FAIL range_next wr=%0d got=%0d want=3", wrs[i], if5.sample_addr);
            end
            abort5 = 1'b1;
            @(negedge clk);
            abort5 = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_wrap5();
        test_backpressure();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
